// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED event scheduler: FSM state encoding,
// default timing constants and the round-robin winner search.
package led_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_t;

    // Default timing: 25 ms ticks at 100 MHz
    localparam int DEF_TICK_DIV  = 2500000;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_CNT_W     = 4;
    localparam int DEF_ON_TICKS  = 4;
    localparam int DEF_OFF_TICKS = 4;
    localparam int DEF_GAP_TICKS = 16;

    // Upper bound on requesters; sets the width of the arbiter vectors
    localparam int MAX_REQ = 8;

    // Returns the first pending index strictly after 'pointer', searching
    // upward and wrapping at num_req. When nothing is pending the pointer
    // itself is returned; callers only use the result when |pending.
    function automatic logic [2:0] rr_winner(
        input logic [MAX_REQ-1:0] pending,
        input logic [2:0]         pointer,
        input int                 num_req
    );
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = pointer;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = int'(pointer) + k;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end else begin
                idx = idx;
            end
            if ((k <= num_req) && !found && pending[idx[2:0]]) begin
                found = 1'b1;
                win   = idx[2:0];
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: tick is high for one clock every TICK_DIV clocks,
// in the cycle where the counter sits at TICK_DIV-1.
module led_tick_gen #(
    parameter int TICK_DIV = 2500000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_r;

    // Prescaler counter: 0..TICK_DIV-1, wraps, never paused
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (count_r == LAST) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

    assign tick = (count_r == LAST);

endmodule

// File: rtl/led_event_scheduler.sv
// Shares one status LED between several event sources. Each source latches a
// request for a burst of N blinks; bursts are granted round-robin and
// sequenced as ON/OFF blink phases followed by a quiet GAP, all timed in
// prescaler ticks.
module led_event_scheduler
    import led_sched_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int GAP_TICKS = DEF_GAP_TICKS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_count,
    output logic                     led,
    output logic                     busy,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     done
);

    // Phase counter must hold the longest phase length minus one
    localparam int MAX_PH = (ON_TICKS > OFF_TICKS) ?
                            ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS) :
                            ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
    localparam int PH_W = $clog2(MAX_PH + 1);

    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);

    logic                 tick_s;

    sched_state_t         state_r;
    sched_state_t         state_nx;
    logic [PH_W-1:0]      phase_r;
    logic [PH_W-1:0]      phase_nx;
    logic [CNT_W-1:0]     remaining_r;
    logic [CNT_W-1:0]     remaining_nx;
    logic [NUM_REQ-1:0]   pending_r;
    logic [NUM_REQ-1:0]   clr_s;
    logic [2:0]           pointer_r;
    logic [2:0]           pointer_nx;
    logic [NUM_REQ-1:0]   grant_r;
    logic [NUM_REQ-1:0]   grant_nx;
    logic                 led_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 done_nx;

    logic [MAX_REQ-1:0]   pending_ext_s;
    logic [2:0]           winner_s;
    logic [NUM_REQ-1:0]   win_onehot_s;
    logic [CNT_W-1:0]     win_count_s;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // Round-robin winner, its one-hot form and its requested blink count
    always_comb begin
        pending_ext_s                = '0;
        pending_ext_s[NUM_REQ-1:0]   = pending_r;
        winner_s                     = rr_winner(pending_ext_s, pointer_r, NUM_REQ);
        win_onehot_s                 = '0;
        win_count_s                  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot_s[i] = (int'(winner_s) == i);
            win_count_s     = win_count_s |
                              (req_count[i*CNT_W +: CNT_W] & {CNT_W{win_onehot_s[i]}});
        end
    end

    // Next-state logic: every transition happens on a tick
    always_comb begin
        state_nx     = state_r;
        phase_nx     = phase_r;
        remaining_nx = remaining_r;
        grant_nx     = grant_r;
        pointer_nx   = pointer_r;
        done_nx      = 1'b0;
        clr_s        = '0;
        if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (enable && (|pending_r)) begin
                        pointer_nx = winner_s;
                        clr_s      = win_onehot_s;
                        if (win_count_s != '0) begin
                            state_nx     = ST_ON;
                            phase_nx     = '0;
                            remaining_nx = win_count_s;
                            grant_nx     = win_onehot_s;
                        end else begin
                            // Zero-length burst: acknowledge without blinking
                            done_nx = 1'b1;
                        end
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_ON: begin
                    if (phase_r == ON_LAST) begin
                        state_nx     = ST_OFF;
                        phase_nx     = '0;
                        remaining_nx = remaining_r - CNT_W'(1);
                    end else begin
                        phase_nx = phase_r + PH_W'(1);
                    end
                end
                ST_OFF: begin
                    if (phase_r == OFF_LAST) begin
                        phase_nx = '0;
                        if (remaining_r != '0) begin
                            state_nx = ST_ON;
                        end else begin
                            state_nx = ST_GAP;
                        end
                    end else begin
                        phase_nx = phase_r + PH_W'(1);
                    end
                end
                ST_GAP: begin
                    if (phase_r == GAP_LAST) begin
                        state_nx = ST_IDLE;
                        phase_nx = '0;
                        grant_nx = '0;
                        done_nx  = 1'b1;
                    end else begin
                        phase_nx = phase_r + PH_W'(1);
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    phase_nx = '0;
                    grant_nx = '0;
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Burst datapath, request latches and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_r     <= '0;
            remaining_r <= '0;
            pending_r   <= '0;
            pointer_r   <= 3'(NUM_REQ - 1);
            grant_r     <= '0;
            led_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            phase_r     <= phase_nx;
            remaining_r <= remaining_nx;
            // A new request in the grant cycle survives the clear
            pending_r   <= (pending_r & ~clr_s) | req;
            pointer_r   <= pointer_nx;
            grant_r     <= grant_nx;
            led_r       <= (state_nx == ST_ON);
            busy_r      <= (state_nx != ST_IDLE);
            done_r      <= done_nx;
        end
    end

    assign led   = led_r;
    assign busy  = busy_r;
    assign grant = grant_r;
    assign done  = done_r;

endmodule

// File: tb/tb_led_event_scheduler.sv
// Self-checking bench for led_event_scheduler: directed scenarios plus a
// randomized run, all compared every cycle against a tick-counting model.
module tb_led_event_scheduler;

    localparam int TDIV = 4;
    localparam int ONT  = 2;
    localparam int OFFT = 2;
    localparam int GAPT = 3;
    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int BLINK = ONT + OFFT;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [NREQ-1:0]  req;
    logic [NREQ*CW-1:0] req_count;
    logic             led;
    logic             busy;
    logic [NREQ-1:0]  grant;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    led_event_scheduler #(
        .TICK_DIV  (TDIV),
        .NUM_REQ   (NREQ),
        .CNT_W     (CW),
        .ON_TICKS  (ONT),
        .OFF_TICKS (OFFT),
        .GAP_TICKS (GAPT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .req_count (req_count),
        .led       (led),
        .busy      (busy),
        .grant     (grant),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a burst is described only by its length n and the
    // number of ticks elapsed since it was granted.
    int              m_div    = 0;
    logic [NREQ-1:0] m_pend   = '0;
    int              m_ptr    = NREQ - 1;
    logic            m_active = 1'b0;
    int              m_n      = 0;
    int              m_e      = 0;
    logic [NREQ-1:0] m_grant  = '0;
    logic            m_done   = 1'b0;

    always @(posedge clk or negedge reset) begin : ref_model
        int              w;
        int              n;
        logic [NREQ-1:0] clr;
        bit              tk;
        if (!reset) begin
            m_div    <= 0;
            m_pend   <= '0;
            m_ptr    <= NREQ - 1;
            m_active <= 1'b0;
            m_n      <= 0;
            m_e      <= 0;
            m_grant  <= '0;
            m_done   <= 1'b0;
        end else begin
            tk  = (m_div == TDIV - 1);
            clr = '0;
            m_div  <= tk ? 0 : m_div + 1;
            m_done <= 1'b0;
            if (tk) begin
                if (m_active) begin
                    m_e <= m_e + 1;
                    if (m_e + 1 == m_n * BLINK + GAPT) begin
                        m_active <= 1'b0;
                        m_grant  <= '0;
                        m_done   <= 1'b1;
                    end
                end else if (enable && (m_pend != '0)) begin
                    w = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        if (w < 0 && m_pend[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                    end
                    m_ptr  <= w;
                    clr[w] = 1'b1;
                    n = int'(req_count[w*CW +: CW]);
                    if (n == 0) begin
                        m_done <= 1'b1;
                    end else begin
                        m_active <= 1'b1;
                        m_n      <= n;
                        m_e      <= 0;
                        m_grant  <= NREQ'(1 << w);
                    end
                end
            end
            m_pend <= (m_pend & ~clr) | req;
        end
    end

    // Per-cycle comparison against the model plus running activity totals
    int              busy_total = 0;
    int              led_total  = 0;
    int              done_total = 0;
    int              led_rises  = 0;
    logic            prev_led   = 1'b0;
    logic [NREQ-1:0] prev_grant = '0;
    logic [NREQ-1:0] grant_log[$];

    always @(negedge clk) begin : monitor
        logic exp_led;
        exp_led = m_active && (m_e < m_n * BLINK) && ((m_e % BLINK) < ONT);
        check("led",   32'(led),   32'(exp_led));
        check("busy",  32'(busy),  32'(m_active));
        check("grant", 32'(grant), 32'(m_grant));
        check("done",  32'(done),  32'(m_done));
        busy_total <= busy_total + (busy ? 1 : 0);
        led_total  <= led_total  + (led ? 1 : 0);
        done_total <= done_total + (done ? 1 : 0);
        led_rises  <= led_rises  + ((led && !prev_led) ? 1 : 0);
        prev_led   <= led;
        if (grant != '0 && prev_grant == '0) grant_log.push_back(grant);
        prev_grant <= grant;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycles(3);
        reset = 1'b1;
        cycles(1);
    endtask

    task automatic set_count(input int s, input int v);
        req_count[s*CW +: CW] = CW'(v);
    endtask

    task automatic pulse_req(input logic [NREQ-1:0] r);
        req = r;
        cycles(1);
        req = '0;
    endtask

    task automatic wait_grant(input string tag, input int bound, input logic [NREQ-1:0] exp);
        int k = 0;
        while (grant == '0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(grant), 32'(exp));
    endtask

    task automatic wait_busy_low(input string tag, input int bound);
        int k = 0;
        while (busy && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_led(input string tag, input int bound);
        int k = 0;
        while (!led && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(led), 32'd1);
    endtask

    int b0, l0, d0, r0, q0, lat;

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        req       = '0;
        req_count = '0;
        cycles(3);
        check("rst_led",   32'(led),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        reset = 1'b1;
        cycles(2);

        // 1. Single request, count 2
        set_count(0, 2);
        b0 = busy_total; l0 = led_total; d0 = done_total;
        pulse_req(4'b0001);
        wait_grant("t1_grant", 8, 4'b0001);
        wait_busy_low("t1_end", 100);
        cycles(3);
        check("t1_busy_cycles", 32'(busy_total - b0), 32'd44);
        check("t1_led_cycles",  32'(led_total - l0),  32'd16);
        check("t1_done_pulses", 32'(done_total - d0), 32'd1);

        // 2. Round-robin with self re-request
        do_reset();
        for (int s = 0; s < NREQ; s++) set_count(s, 1);
        q0 = grant_log.size();
        pulse_req(4'b1111);
        wait_grant("t2_first", 8, 4'b0001);
        cycles(3);
        pulse_req(4'b0001);
        cycles(200);
        wait_busy_low("t2_end", 100);
        check("t2_grants", 32'(grant_log.size() - q0), 32'd5);
        if (grant_log.size() >= q0 + 5) begin
            check("t2_order0", 32'(grant_log[q0]),     32'b0001);
            check("t2_order1", 32'(grant_log[q0 + 1]), 32'b0010);
            check("t2_order2", 32'(grant_log[q0 + 2]), 32'b0100);
            check("t2_order3", 32'(grant_log[q0 + 3]), 32'b1000);
            check("t2_order4", 32'(grant_log[q0 + 4]), 32'b0001);
        end

        // 3. Zero count
        set_count(2, 0);
        b0 = busy_total; l0 = led_total; d0 = done_total;
        pulse_req(4'b0100);
        cycles(12);
        check("t3_done",   32'(done_total - d0), 32'd1);
        check("t3_busy",   32'(busy_total - b0), 32'd0);
        check("t3_led",    32'(led_total - l0),  32'd0);
        cycles(20);
        check("t3_pending_cleared", 32'(done_total - d0), 32'd1);

        // 4. Enable gating mid-burst
        set_count(3, 3);
        set_count(1, 1);
        pulse_req(4'b1010);
        wait_grant("t4_grant3", 8, 4'b1000);
        wait_led("t4_on", 12);
        enable = 1'b0;
        wait_busy_low("t4_burst_end", 200);
        cycles(30);
        check("t4_hold_grant", 32'(grant), 32'd0);
        check("t4_hold_busy",  32'(busy),  32'd0);
        enable = 1'b1;
        lat = 0;
        while (grant == '0 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("t4_grant1",  32'(grant), 32'b0010);
        check("t4_latency", 32'(lat <= TDIV), 32'd1);
        wait_busy_low("t4_end", 100);

        // 5. Async reset during ON
        set_count(0, 2);
        set_count(2, 2);
        pulse_req(4'b0101);
        wait_led("t5_on", 12);
        #1;
        reset = 1'b0;
        #1;
        check("t5_led_async",   32'(led),   32'd0);
        check("t5_grant_async", 32'(grant), 32'd0);
        check("t5_busy_async",  32'(busy),  32'd0);
        cycles(3);
        reset = 1'b1;
        b0 = busy_total;
        cycles(60);
        check("t5_no_service", 32'(busy_total - b0), 32'd0);

        // 6. Maximum count
        set_count(1, 15);
        b0 = busy_total; l0 = led_total; d0 = done_total; r0 = led_rises;
        pulse_req(4'b0010);
        wait_grant("t6_grant", 8, 4'b0010);
        set_count(1, 3);
        wait_busy_low("t6_end", 400);
        cycles(3);
        check("t6_busy_cycles", 32'(busy_total - b0), 32'((15 * BLINK + GAPT) * TDIV));
        check("t6_led_cycles",  32'(led_total - l0),  32'(15 * ONT * TDIV));
        check("t6_on_phases",   32'(led_rises - r0),  32'd15);
        check("t6_done",        32'(done_total - d0), 32'd1);

        // Randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < NREQ; s++) begin
                req[s] = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 15) == 0) begin
                    int r;
                    r = int'($urandom_range(0, 19));
                    set_count(s, (r == 19) ? 15 : (r % 4));
                end
            end
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            cycles(1);
        end
        req    = '0;
        enable = 1'b1;
        cycles(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_event_scheduler.md
Name: led_event_scheduler

Overview:
- Shares the single board status LED between up to NUM_REQ event sources, e.g. PDM FIFO overflow, underflow, stream-active and heartbeat.
- Each source requests a burst of N blinks.
- The block latches requests, arbitrates round-robin, and sequences ON/OFF/GAP phases on a prescaled tick.
- Sits between the PDM stream status logic and the LED pin, replacing free-running blink logic.

Parameters:
- TICK_DIV, 2_500_000, clk cycles per tick (25 ms at 100 MHz); must be >= 2.
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 4, width of each per-requester blink count.
- ON_TICKS, 4, ticks LED is high per blink (>= 1).
- OFF_TICKS, 4, ticks LED is low between blinks (>= 1).
- GAP_TICKS, 16, ticks LED is low after a burst before the next grant (>= 1).

Ports:
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-low; all state clears immediately while low.
- enable, in, 1, allows new grants; does not abort a running burst.
- req, in, NUM_REQ, per-source request; a level held high for any cycle sets that source's pending bit.
- req_count, in, NUM_REQ*CNT_W, blink count per source (source i in bits [i*CNT_W +: CNT_W]); sampled at grant.
- led, out, 1, LED drive, registered.
- busy, out, 1, high whenever the state is not IDLE.
- grant, out, NUM_REQ, one-hot owner of the current burst; 0 in IDLE.
- done, out, 1, one-cycle pulse at the end of each served request.

Behaviour:
- Reset values:
  - led=0, busy=0, grant=0, done=0, pending=0, state=IDLE.
  - Prescaler=0; round-robin pointer=NUM_REQ-1, so source 0 has first priority.
- Prescaler (sub-module):
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly one cycle when the count equals TICK_DIV-1.
  - Free-running regardless of state or enable.
- Pending:
  - pending[i] <= (pending[i] & ~clr[i]) | req[i]. Set wins over clear in the same cycle.
  - clr[i] is asserted in the cycle source i is granted.
- Arbitration:
  - Evaluated only in IDLE on a cycle with tick=1, enable=1 and |pending.
  - Winner is the first pending index after the pointer, searching upward with wraparound.
  - Pointer <= winner.
- FSM states: IDLE, ON, OFF, GAP. All transitions happen on tick; a phase counter counts ticks and resets to 0 on every state change.
  - IDLE -> ON: winner chosen and latched count n != 0.
    - grant <= onehot(winner), remaining <= n, clear pending[winner].
    - led=1 from the next cycle.
  - IDLE, n == 0: clear pending, pulse done for one cycle, stay IDLE; no blink and no gap.
  - ON -> OFF: when phase == ON_TICKS-1 on a tick. remaining <= remaining-1, led <= 0.
  - OFF -> ON: when phase == OFF_TICKS-1 and remaining != 0.
  - OFF -> GAP: when phase == OFF_TICKS-1 and remaining == 0.
  - GAP -> IDLE: when phase == GAP_TICKS-1. done pulses for 1 cycle, grant <= 0.
- Timing:
  - Exact durations: ON = ON_TICKS*TICK_DIV cycles, OFF = OFF_TICKS*TICK_DIV, GAP = GAP_TICKS*TICK_DIV.
  - Grant-to-LED latency is 1 cycle after the granting tick.
- Outputs:
  - led is high only in ON.
  - busy=1 in ON, OFF and GAP.
- Boundaries:
  - A req from the granted source during its own burst re-sets its pending bit; it is served again after the other pending sources per round-robin.
  - enable dropping mid-burst: the burst and gap complete, then the FSM holds in IDLE, pending bits are retained, and service resumes on the first tick after enable returns.
  - req_count changing mid-burst has no effect.
  - Maximum count 2^CNT_W-1 is handled without overflow.
  - reset asserted mid-burst: led drops to 0 asynchronously and all pending requests are lost.

Decomposition:
- Shared package (led_sched_pkg):
  - FSM state enum (2 bits).
  - Default timing constants.
  - Function returning the round-robin winner index from (pending, pointer).
- One sub-module, led_tick_gen: the prescaler.
  - Parameter TICK_DIV; ports clk, reset, tick.
  - Counter width $clog2(TICK_DIV).

Test Plan:
Test config: TICK_DIV=4, ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=3, NUM_REQ=4, CNT_W=4; enable=1 unless stated.
1. Single request: pulse req[0] with count0=2.
   - grant=0001 after the next tick.
   - led pattern high 8, low 8, high 8, low 8, then low 12 (gap); done pulses once; busy is high for 44 cycles.
2. Round-robin: req=1111 set simultaneously, all counts=1.
   - Grant order 0, 1, 2, 3.
   - Re-requesting 0 during its own burst serves it after 3 (order 0, 1, 2, 3, 0).
3. Zero count: req[2] with count2=0.
   - done pulses on the next tick, led stays 0, busy stays 0, pending[2] clears.
4. Enable gating: drop enable mid-ON of a count=3 burst with req[1] pending.
   - The burst and gap complete; no further grant while enable=0.
   - grant=0010 on the first tick after enable=1.
5. Async reset: assert reset during ON with two requests pending.
   - led=0, grant=0, busy=0 within the same cycle, without waiting for a clock edge.
   - After release, nothing is served until new requests arrive.
6. Max count: count=15.
   - Exactly 15 ON phases, then gap, then done; no wraparound of the remaining counter.
